// File: rtl/fifo_pack_if.sv
// Beat-in / word-out bus of the fifo packer: valid/ready beat stream on one side,
// psh/din/full triple toward the downstream fifo on the other.
interface fifo_pack_if #(
    parameter int IN_W  = 8,
    parameter int RATIO = 4
);
    localparam int OUT_W = IN_W*RATIO + $clog2(RATIO) + 1;

    logic             in_val;
    logic [IN_W-1:0]  in_dat;
    logic             in_last;
    logic             in_rdy;
    logic             psh;
    logic [OUT_W-1:0] din;
    logic             full;

    modport master (output in_val, in_dat, in_last, full, input in_rdy, psh, din);
    modport slave  (input in_val, in_dat, in_last, full, output in_rdy, psh, din);
endinterface

// File: rtl/fifo_pack.sv
// Packs RATIO narrow beats (or fewer, on in_last) into one wide word with a lane
// count, staged in a single register so psh is never raised while full is high.
module fifo_pack #(
    parameter int IN_W  = 8,
    parameter int RATIO = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    fifo_pack_if.slave bus
);
    localparam int DAT_W = IN_W*RATIO;
    localparam int CW    = $clog2(RATIO) + 1;
    localparam int OUT_W = DAT_W + CW;
    localparam int ACC_N = (RATIO > 1) ? RATIO-1 : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO-1);

    logic [CW-1:0]              lane_q, lane_d;
    logic [ACC_N-1:0][IN_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0]           pend_dat_q, pend_dat_d;
    logic                       pend_val_q, pend_val_d;
    logic                       accept, complete, push;
    logic [RATIO-1:0][IN_W-1:0] acc_ext, word;

    assign push       = pend_val_q & ~bus.full;
    assign bus.psh    = push;
    assign bus.din    = pend_dat_q;
    // Stalls every beat while the staged word is blocked, not only completing ones.
    assign bus.in_rdy = ~(pend_val_q & bus.full);
    assign accept     = bus.in_val & bus.in_rdy;
    assign complete   = accept & ((lane_q == LAST_LANE) | bus.in_last);
    assign acc_ext    = DAT_W'(acc_q);

    always_comb begin
        word = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (CW'(k) == lane_q)     word[k] = bus.in_dat;
            else if (CW'(k) < lane_q) word[k] = acc_ext[k];
        end
    end

    always_comb begin
        lane_d     = lane_q;
        acc_d      = acc_q;
        pend_dat_d = pend_dat_q;
        pend_val_d = pend_val_q;
        if (complete) begin
            // A push in this same cycle is overwritten by the reload, so pend stays valid.
            pend_dat_d = {lane_q + CW'(1), word};
            pend_val_d = 1'b1;
            lane_d     = '0;
            acc_d      = '0;
        end else begin
            if (push) pend_val_d = 1'b0;
            if (accept) begin
                for (int k = 0; k < ACC_N; k++)
                    if (lane_q == CW'(k)) acc_d[k] = bus.in_dat;
                lane_d = lane_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q     <= '0;
            acc_q      <= '0;
            pend_dat_q <= '0;
            pend_val_q <= 1'b0;
        end else begin
            lane_q     <= lane_d;
            acc_q      <= acc_d;
            pend_dat_q <= pend_dat_d;
            pend_val_q <= pend_val_d;
        end
    end
endmodule

// File: tb/tb_fifo_pack.sv
// Scoreboard bench for fifo_pack: a beat-list model builds expected words on
// acceptance, a monitor pops and compares on every push.
module tb_fifo_pack;
    localparam int IN_W  = 8;
    localparam int RATIO = 4;
    localparam int DAT_W = IN_W*RATIO;
    localparam int CW    = $clog2(RATIO) + 1;
    localparam int OUT_W = DAT_W + CW;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fifo_pack_if #(.IN_W(IN_W), .RATIO(RATIO)) bus ();
    fifo_pack #(.IN_W(IN_W), .RATIO(RATIO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    fifo_pack_if #(.IN_W(8), .RATIO(1)) bus1 ();
    fifo_pack #(.IN_W(8), .RATIO(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_chk  = 0;
    int n_pass = 0;
    logic [OUT_W-1:0] exp_q[$];
    logic [IN_W-1:0]  beats[$];
    bit rnd_full = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [OUT_W-1:0] pack(input logic [IN_W-1:0] b[$]);
        logic [OUT_W-1:0] w = '0;
        for (int i = 0; i < b.size(); i++) w[i*IN_W +: IN_W] = b[i];
        w[DAT_W +: CW] = CW'(b.size());
        return w;
    endfunction

    task automatic model_accept(input logic [IN_W-1:0] d, input bit last);
        beats.push_back(d);
        if (last || beats.size() == RATIO) begin
            exp_q.push_back(pack(beats));
            beats.delete();
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the beat transfers.
    task automatic send(input logic [IN_W-1:0] d, input bit last);
        int t = 0;
        bus.in_val = 1'b1; bus.in_dat = d; bus.in_last = last;
        #1;
        while (!bus.in_rdy && t < 200) begin
            @(negedge clk); #1; t++;
        end
        if (!bus.in_rdy) begin
            n_chk++;
            $display("FAIL send_timeout: in_rdy %0d after 200 cycles, need 1", bus.in_rdy);
        end else model_accept(d, last);
        @(negedge clk);
        bus.in_val = 1'b0; bus.in_last = 1'b0;
    endtask

    always @(negedge clk) if (rnd_full) bus.full = ($urandom_range(0, 2) == 0);

    always @(negedge clk) begin
        #2;
        if (rst_n && bus.psh) begin
            chk("psh_while_full", bus.full, 0);
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_push: din %0h with no word expected", bus.din);
            end else chk("word", bus.din, exp_q.pop_front());
        end
    end

    initial begin
        bus.in_val = 1'b0; bus.in_dat = '0; bus.in_last = 1'b0; bus.full = 1'b0;
        bus1.in_val = 1'b0; bus1.in_dat = '0; bus1.in_last = 1'b0; bus1.full = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_psh", bus.psh, 0);
        chk("rst_din", bus.din, 0);
        chk("rst_rdy", bus.in_rdy, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // RATIO = 1: every beat is a word, pushed on consecutive cycles
        bus1.in_val = 1'b1; bus1.in_dat = 8'h7E;
        @(negedge clk);
        bus1.in_dat = 8'h7F;
        #2;
        chk("r1_psh0", bus1.psh, 1);
        chk("r1_din0", bus1.din, 9'h17E);
        @(negedge clk);
        bus1.in_val = 1'b0;
        #2;
        chk("r1_psh1", bus1.psh, 1);
        chk("r1_din1", bus1.din, 9'h17F);
        @(negedge clk);
        #2;
        chk("r1_idle", bus1.psh, 0);
        @(negedge clk);

        // full word, one-cycle latency to psh
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        #2;
        chk("full_word_psh", bus.psh, 1);
        chk("full_word_din", bus.din, {3'd4, 32'h44332211});
        @(negedge clk);

        // early close, then a fresh word from lane 0
        send(8'hAA, 0); send(8'hBB, 1);
        send(8'hCC, 0); send(8'hCD, 0); send(8'hCE, 0); send(8'hCF, 0);
        repeat (2) @(negedge clk);

        // backpressure: staged word held while full, released the cycle full falls
        send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0);
        bus.full = 1'b1;
        send(8'hA4, 0);
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("bp_psh", bus.psh, 0);
            chk("bp_rdy", bus.in_rdy, 0);
            chk("bp_din", bus.din, exp_q.size() > 0 ? exp_q[0] : '1);
            @(negedge clk);
        end
        bus.full = 1'b0;
        #1;
        chk("bp_rel_psh", bus.psh, 1);
        chk("bp_rel_rdy", bus.in_rdy, 1);
        @(negedge clk);

        // streaming: back-to-back words with in_rdy held high
        for (int i = 1; i <= 12; i++) begin
            #1 chk("stream_rdy", bus.in_rdy, 1);
            send(IN_W'(i), 0);
        end
        repeat (2) @(negedge clk);
        chk("stream_drain", exp_q.size(), 0);

        // reset mid-word discards the partial word
        send(8'h31, 0); send(8'h32, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_psh", bus.psh, 0);
        chk("mid_rst_din", bus.din, 0);
        chk("mid_rst_rdy", bus.in_rdy, 1);
        beats.delete(); exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h51, 0); send(8'h52, 0); send(8'h53, 0); send(8'h54, 0);
        repeat (2) @(negedge clk);

        // randomized beats, packet ends and fifo backpressure
        rnd_full = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            else send(IN_W'($urandom), $urandom_range(0, 4) == 0);
        end
        rnd_full = 1'b0;
        @(negedge clk);
        bus.full = 1'b0;
        repeat (6) @(negedge clk);
        chk("final_drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fifo_pack.md
# fifo_pack

Upstream packer for the core's `fifo` block. It accepts a stream of narrow beats on a valid/ready handshake and assembles `RATIO` beats into one wide word. Each completed word is pushed into a downstream `fifo` through that block's `psh`/`din`/`full` port triple. A single-entry staging register guarantees that `psh` is never asserted while `full` is high, because the `fifo` has no overflow protection.

## Interface
- `IN_W`, default 8: width of one input beat.
- `RATIO`, default 4: beats per output word; any integer ≥ 1.
- Derived `DAT_W = IN_W*RATIO`.
- Derived `CW = $clog2(RATIO)+1`: width of the lane-count field.
- Derived `OUT_W = DAT_W + CW`: width of the output word.
- `clk`  in  1  clock; the block uses one clock and all state is on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_val`  in  1  input beat valid.
- `in_dat`  in  IN_W  input beat data.
- `in_last`  in  1  the beat is the final beat of a packet and closes the current word early.
- `in_rdy`  out  1  block can accept a beat; a beat transfers when `in_val & in_rdy`.
- `psh`  out  1  push strobe to the `fifo`.
- `din`  out  OUT_W  word to the `fifo`.
  - `din[DAT_W-1:0]` is the data; lane k occupies `[k*IN_W +: IN_W]`.
  - `din[OUT_W-1:DAT_W]` is the number of valid lanes, in the range 1..RATIO.
- `full`  in  1  `fifo` full flag.

## Operation
- **State:**
  - lane counter `lane` (CW bits, range 0..RATIO-1).
  - accumulator holding lanes 0..RATIO-2.
  - staging register `pend_dat` (OUT_W bits) with flag `pend_val`.
- **Lane order:** the first beat of a word goes to lane 0 (LSBs), and each later beat goes to the next lane.
- **Non-completing beat** (accepted, `lane != RATIO-1` and `!in_last`):
  - store the beat in the accumulator at position `lane`;
  - `lane <= lane+1`.
- **Completing beat** (accepted, and `lane == RATIO-1` or `in_last`):
  - `pend_dat <= {lane+1, in_dat placed at lane position, accumulator lanes 0..lane-1}`;
  - lanes above `lane` are zero-filled;
  - `pend_val <= 1`;
  - `lane <= 0`;
  - clear the accumulator.
- **Push:**
  - `psh = pend_val & !full` (combinational).
  - `din = pend_dat`.
  - When `psh` is high and no completing beat is accepted in the same cycle, `pend_val <= 0`.
- **Drain and reload in the same cycle:** if `psh` is high and a completing beat is accepted, `pend` reloads with the new word and `pend_val` stays 1.
- **Ready:** `in_rdy = !(pend_val & full)`.
  - This is deliberately conservative: non-completing beats also stall while the staged word is blocked.
  - `in_rdy` does not depend on `in_val`, `in_dat` or `in_last`.
- **`in_last` on lane 0:** produces a word with lane count 1.
- **`RATIO == 1`:** every accepted beat is a completing beat; the accumulator is empty.
- **`in_val` low:** no state changes other than the push drain.

## Timing
- **Reset:** `rst_n` low asynchronously clears `lane`, the accumulator, `pend_dat` and `pend_val`. Output values during and after reset:
  - `psh = 0`;
  - `din = 0`;
  - `in_rdy = 1`.
- **Latency:** a completing beat accepted in cycle t gives `psh = 1` in cycle t+1 if `full` is low in t+1.
- **Throughput:** with `full` low, one beat is accepted every cycle. Words are pushed back-to-back with no bubbles; for example, RATIO=1 pushes every cycle.
- **`full` high with `pend_val` set:**
  - `psh = 0`, and `din` holds stable;
  - `in_rdy = 0`;
  - the accumulator and `lane` hold.
- **`full` falls:** in the same cycle, `psh = 1` and `in_rdy = 1`.
- **`full` with `pend_val` low:** `full` has no effect; beats keep accumulating until the next completing beat.
- **Reset mid-word:** the partial word and any staged word are discarded. The first beat after reset goes to lane 0.
- **Bound on `psh`:** `psh` is never high in a cycle where `full` is high.

## Test plan
Unless noted, `IN_W = 8` and `RATIO = 4`.
- **Full word:** beats 0x11, 0x22, 0x33, 0x44 in cycles 1–4 with `full = 0` -> `psh` in cycle 5 with `din` data = 0x44332211 and lane count = 4. `psh` is low in all other cycles.
- **Early close:** beats 0xAA, then 0xBB with `in_last = 1` -> data = 0x0000BBAA, lane count = 2. The next beat 0xCC followed by 3 more beats lands in lane 0.
- **Backpressure:** `full = 1` from cycle 4. After the word completes, `psh` stays 0, `din` is stable and `in_rdy` is 0 until `full` drops in cycle 9. In cycle 9, `psh` is 1 and `in_rdy` is 1. No word is lost or duplicated.
- **Streaming:** 12 consecutive beats 0x01..0x0C with `full = 0` -> `psh` in cycles 5, 9 and 13 with data 0x04030201, 0x08070605 and 0x0C0B0A09. `in_rdy` stays 1 throughout.
- **Reset mid-word:** 2 beats, then `rst_n` low asynchronously mid-cycle -> `psh = 0`, `din = 0` and `in_rdy = 1` immediately. Four further beats 0x51..0x54 give data 0x54535251.
- **RATIO = 1:** beats 0x7E, then 0x7F -> `psh` in 2 consecutive cycles with `din` = {1, 0x7E} and then {1, 0x7F}.
